// File: rtl/mmio_console_ctrl_if.sv
// MMIO access channel for the console controller.
// Signals: mmio_req_i (one-cycle access strobe), mmio_addr_i (byte address),
// mmio_wdata_i / mmio_strb_i (write data and byte enables), mmio_we_i
// (1 = write), mmio_rdata_o (registered read data, one cycle after request).
// The master modport drives the request side; the slave modport answers it.
interface mmio_console_ctrl_if #(
  parameter int unsigned MMIOAddrWidth = 31,
  parameter int unsigned DataWidth     = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic                     mmio_req_i;
  logic [MMIOAddrWidth-1:0] mmio_addr_i;
  logic [DataWidth-1:0]     mmio_wdata_i;
  logic [StrbWidth-1:0]     mmio_strb_i;
  logic                     mmio_we_i;
  logic [DataWidth-1:0]     mmio_rdata_o;

  modport master (
    output mmio_req_i, mmio_addr_i, mmio_wdata_i, mmio_strb_i, mmio_we_i,
    input  mmio_rdata_o
  );

  modport slave (
    input  mmio_req_i, mmio_addr_i, mmio_wdata_i, mmio_strb_i, mmio_we_i,
    output mmio_rdata_o
  );
endinterface

// File: rtl/mmio_console_ctrl.sv
// Simulation console controller: an MMIO register window that queues printed
// characters into a TX FIFO, latches a one-shot test-end code and exposes a
// status register and (optionally) a free-running cycle counter.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mmio                   MMIO slave channel (request in, registered rdata out)
//   char_valid_o, char_o   TX character stream, head of the FIFO (registered)
//   char_ready_i           sink accepts char_o
//   stop_o, stop_code_o    sticky test-end flag and its result code
//
// Register map (addr[4:3]): 0 PRINT, 1 STOP, 2 STATUS, 3 CYCLE.
// Build option: define MMIO_CONSOLE_CYCLE_COUNTER_EN to include the 64-bit
// cycle counter; without it CYCLE reads 0 and no counter flops exist.
module mmio_console_ctrl #(
  parameter int unsigned              MMIOAddrWidth = 31,
  parameter int unsigned              DataWidth     = 64,
  parameter int unsigned              FifoDepth     = 16,
  parameter logic [MMIOAddrWidth-1:0] BaseAddr      = MMIOAddrWidth'(31'h1000_0000)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  mmio_console_ctrl_if.slave        mmio,
  output logic                      char_valid_o,
  output logic [7:0]                char_o,
  input  logic                      char_ready_i,
  output logic                      stop_o,
  output logic [31:0]               stop_code_o
);
  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  typedef enum logic [1:0] {
    RegPrint  = 2'd0,
    RegStop   = 2'd1,
    RegStatus = 2'd2,
    RegCycle  = 2'd3
  } reg_sel_e;

  logic [7:0]          mem [FifoDepth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                ovf_q;
  logic [63:0]         cycle_val;

  logic                hit, push, pop, full, push_ok, ovf_set, stop_load;
  reg_sel_e            sel;
  logic [CntWidth-1:0] count_n;
  logic [PtrWidth-1:0] rd_ptr_n;
  logic [7:0]          head_n;
  logic [63:0]         rdata_wide;
  logic [DataWidth-1:0] rdata_n;

  // Address decode, FIFO bookkeeping and read-data selection.
  always_comb begin
    hit        = 1'b0;
    sel        = RegPrint;
    push       = 1'b0;
    pop        = 1'b0;
    full       = 1'b0;
    push_ok    = 1'b0;
    ovf_set    = 1'b0;
    stop_load  = 1'b0;
    count_n    = count_q;
    rd_ptr_n   = rd_ptr_q;
    head_n     = 8'h00;
    rdata_wide = 64'h0;
    rdata_n    = '0;

    hit  = mmio.mmio_req_i &&
           (mmio.mmio_addr_i[MMIOAddrWidth-1:5] == BaseAddr[MMIOAddrWidth-1:5]);
    sel  = reg_sel_e'(mmio.mmio_addr_i[4:3]);
    push = hit && mmio.mmio_we_i && (sel == RegPrint) && mmio.mmio_strb_i[0];
    pop  = char_valid_o && char_ready_i;
    full = (count_q == CntWidth'(FifoDepth));
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    push_ok   = push && (!full || pop);
    ovf_set   = push && full && !pop;
    stop_load = hit && mmio.mmio_we_i && (sel == RegStop) && !stop_o;

    count_n  = count_q + CntWidth'(push_ok) - CntWidth'(pop);
    rd_ptr_n = rd_ptr_q + PtrWidth'(pop);
    // The incoming byte becomes the head when it lands at the new read slot.
    if (count_n == '0)
      head_n = 8'h00;
    else if (push_ok && (wr_ptr_q == rd_ptr_n))
      head_n = mmio.mmio_wdata_i[7:0];
    else
      head_n = mem[rd_ptr_n];

    if (hit && !mmio.mmio_we_i) begin
      unique case (sel)
        RegPrint:  rdata_wide = 64'h0;
        RegStop:   rdata_wide = {31'b0, stop_o, stop_code_o};
        RegStatus: rdata_wide = {ovf_q, 47'b0, 16'(count_q)};
        RegCycle:  rdata_wide = cycle_val;
        default:   rdata_wide = 64'h0;
      endcase
    end
    rdata_n = DataWidth'(rdata_wide);
  end

  // Character storage; validity is tracked by count_q, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= mmio.mmio_wdata_i[7:0];
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      ovf_q             <= 1'b0;
      char_valid_o      <= 1'b0;
      char_o            <= 8'h00;
      stop_o            <= 1'b0;
      stop_code_o       <= 32'h0;
      mmio.mmio_rdata_o <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      rd_ptr_q          <= rd_ptr_n;
      count_q           <= count_n;
      if (ovf_set) ovf_q <= 1'b1;
      char_valid_o      <= (count_n != '0);
      char_o            <= head_n;
      if (stop_load) begin
        stop_o      <= 1'b1;
        stop_code_o <= mmio.mmio_wdata_i[31:0];
      end
      mmio.mmio_rdata_o <= rdata_n;
    end
  end

`ifdef MMIO_CONSOLE_CYCLE_COUNTER_EN
  logic [63:0] cycle_q;

  // Free-running cycle counter, wraps naturally at 2^64.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle_q <= 64'h0;
    else         cycle_q <= cycle_q + 64'd1;
  end
  assign cycle_val = cycle_q;
`else
  assign cycle_val = 64'h0;
`endif

  // Address offset bits, upper write data and upper strobes carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{mmio.mmio_addr_i[2:0], mmio.mmio_wdata_i, mmio.mmio_strb_i};
endmodule

// File: tb/tb_mmio_console_ctrl.sv
// Directed self-checking bench for mmio_console_ctrl (default parameters).
module tb_mmio_console_ctrl;
  localparam logic [30:0] A_PRINT  = 31'h1000_0000;
  localparam logic [30:0] A_STOP   = 31'h1000_0008;
  localparam logic [30:0] A_STATUS = 31'h1000_0010;
  localparam logic [30:0] A_CYCLE  = 31'h1000_0018;
  localparam logic [30:0] A_MISS   = 31'h1000_0038;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        char_valid_o;
  logic [7:0]  char_o;
  logic        char_ready_i = 1'b0;
  logic        stop_o;
  logic [31:0] stop_code_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];

  always #5 clk_i = ~clk_i;

  mmio_console_ctrl_if #(.MMIOAddrWidth(31), .DataWidth(64)) mmio ();

  mmio_console_ctrl #(
    .MMIOAddrWidth(31),
    .DataWidth(64),
    .FifoDepth(16),
    .BaseAddr(31'h1000_0000)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .mmio(mmio),
    .char_valid_o(char_valid_o),
    .char_o(char_o),
    .char_ready_i(char_ready_i),
    .stop_o(stop_o),
    .stop_code_o(stop_code_o)
  );

  // Capture every accepted character.
  always @(posedge clk_i) begin
    if (char_valid_o && char_ready_i) rx_q.push_back(char_o);
  end

  // One bus access; entered and left at posedge+1.
  task automatic bus(input logic we, input logic [30:0] addr, input logic [63:0] wdata,
                     input logic [7:0] strb, output logic [63:0] rdata);
    mmio.mmio_req_i   = 1'b1;
    mmio.mmio_we_i    = we;
    mmio.mmio_addr_i  = addr;
    mmio.mmio_wdata_i = wdata;
    mmio.mmio_strb_i  = strb;
    @(posedge clk_i); #1;
    mmio.mmio_req_i   = 1'b0;
    mmio.mmio_we_i    = 1'b0;
    mmio.mmio_strb_i  = 8'h00;
    rdata = mmio.mmio_rdata_o;
  endtask

  task automatic wr(input logic [30:0] addr, input logic [63:0] wdata);
    logic [63:0] d;
    bus(1'b1, addr, wdata, 8'hFF, d);
  endtask

  task automatic rd(input logic [30:0] addr, output logic [63:0] rdata);
    bus(1'b0, addr, 64'h0, 8'h00, rdata);
  endtask

  task automatic do_reset();
    char_ready_i = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    mmio.mmio_req_i = 1'b0; mmio.mmio_we_i = 1'b0; mmio.mmio_addr_i = '0;
    mmio.mmio_wdata_i = '0; mmio.mmio_strb_i = '0;
    repeat (2) @(posedge clk_i); #1;
    n_cmp++; if (mmio.mmio_rdata_o !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", mmio.mmio_rdata_o); end
    n_cmp++; if (char_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", char_valid_o); end
    n_cmp++; if (char_o !== 8'h00) begin n_fail++; $display("FAIL reset_char: got %h want 0", char_o); end
    n_cmp++; if (stop_o !== 1'b0) begin n_fail++; $display("FAIL reset_stop: got %b want 0", stop_o); end
    n_cmp++; if (stop_code_o !== 32'h0) begin n_fail++; $display("FAIL reset_code: got %h want 0", stop_code_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    rd(A_STATUS, d);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_print_order();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    rx_q.delete();
    char_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) wr(A_PRINT, {56'h0, exp[i]});
    repeat (4) @(posedge clk_i); #1;
    n_cmp++; if (rx_q.size() !== 3) begin n_fail++; $display("FAIL print_count: got %0d want 3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL print_char%0d: got %h want %h", i, rx_q[i], exp[i]); end
    end
    n_cmp++; if (char_valid_o !== 1'b0) begin n_fail++; $display("FAIL print_idle_valid: got %b want 0", char_valid_o); end
  endtask

  task automatic test_strb();
    logic [63:0] d;
    char_ready_i = 1'b0;
    bus(1'b1, A_PRINT, 64'h77, 8'hFE, d);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL write_rdata: got %h want 0", d); end
    rd(A_STATUS, d);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL strb0_status: got %h want 0", d); end
    n_cmp++; if (char_valid_o !== 1'b0) begin n_fail++; $display("FAIL strb0_valid: got %b want 0", char_valid_o); end
  endtask

  task automatic test_full_push_pop();
    logic [63:0] d;
    do_reset();
    rx_q.delete();
    for (int i = 0; i < 16; i++) wr(A_PRINT, 64'(8'h10 + i));
    rd(A_STATUS, d);
    n_cmp++; if (d !== 64'h10) begin n_fail++; $display("FAIL full_status: got %h want 10", d); end
    n_cmp++; if (char_o !== 8'h10) begin n_fail++; $display("FAIL full_head: got %h want 10", char_o); end
    char_ready_i = 1'b1;
    wr(A_PRINT, 64'h20);
    char_ready_i = 1'b0;
    rd(A_STATUS, d);
    n_cmp++; if (d !== 64'h10) begin n_fail++; $display("FAIL pushpop_status: got %h want 10", d); end
    n_cmp++; if (char_o !== 8'h11) begin n_fail++; $display("FAIL pushpop_head: got %h want 11", char_o); end
    char_ready_i = 1'b1;
    repeat (20) @(posedge clk_i); #1;
    n_cmp++; if (rx_q.size() !== 17) begin n_fail++; $display("FAIL pushpop_drain_count: got %0d want 17", rx_q.size()); end
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL pushpop_char%0d: got %h want %h", i, rx_q[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] d;
    do_reset();
    rx_q.delete();
    for (int i = 1; i <= 17; i++) wr(A_PRINT, 64'(i));
    rd(A_STATUS, d);
    n_cmp++; if (d !== 64'h8000_0000_0000_0010) begin n_fail++; $display("FAIL ovf_status: got %h want 8000000000000010", d); end
    char_ready_i = 1'b1;
    repeat (20) @(posedge clk_i); #1;
    n_cmp++; if (rx_q.size() !== 16) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 16", rx_q.size()); end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL ovf_char%0d: got %h want %h", i, rx_q[i], 8'(i + 1)); end
    end
    n_cmp++; if (char_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_idle_valid: got %b want 0", char_valid_o); end
    rd(A_STATUS, d);
    n_cmp++; if (d !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovf_sticky: got %h want 8000000000000000", d); end
  endtask

  task automatic test_stop();
    logic [63:0] d;
    n_cmp++; if (stop_o !== 1'b0) begin n_fail++; $display("FAIL stop_pre: got %b want 0", stop_o); end
    wr(A_STOP, 64'h1);
    n_cmp++; if (stop_o !== 1'b1) begin n_fail++; $display("FAIL stop_set: got %b want 1", stop_o); end
    n_cmp++; if (stop_code_o !== 32'h1) begin n_fail++; $display("FAIL stop_code_first: got %h want 1", stop_code_o); end
    wr(A_STOP, 64'h5);
    n_cmp++; if (stop_code_o !== 32'h1) begin n_fail++; $display("FAIL stop_code_kept: got %h want 1", stop_code_o); end
    rd(A_STOP, d);
    n_cmp++; if (d !== 64'h1_0000_0001) begin n_fail++; $display("FAIL stop_read: got %h want 100000001", d); end
    rd(A_PRINT, d);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL print_read: got %h want 0", d); end
    rd(A_MISS, d);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL miss_read: got %h want 0", d); end
    rx_q.delete();
    char_ready_i = 1'b1;
    wr(A_PRINT, 64'h55);
    repeat (3) @(posedge clk_i); #1;
    n_cmp++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL after_stop_count: got %0d want 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      n_cmp++; if (rx_q[0] !== 8'h55) begin n_fail++; $display("FAIL after_stop_char: got %h want 55", rx_q[0]); end
    end
  endtask

  task automatic test_cycle();
    logic [63:0] a, b;
    rd(A_CYCLE, a);
    repeat (9) @(posedge clk_i); #1;
    rd(A_CYCLE, b);
`ifdef MMIO_CONSOLE_CYCLE_COUNTER_EN
    n_cmp++; if (b - a !== 64'd10) begin n_fail++; $display("FAIL cycle_delta: got %0d want 10", b - a); end
    n_cmp++; if (a === 64'h0) begin n_fail++; $display("FAIL cycle_running: got %h want nonzero", a); end
`else
    n_cmp++; if (a !== 64'h0) begin n_fail++; $display("FAIL cycle_first: got %h want 0", a); end
    n_cmp++; if (b !== 64'h0) begin n_fail++; $display("FAIL cycle_second: got %h want 0", b); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    char_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) wr(A_PRINT, 64'(8'hA0 + i));
    n_cmp++; if (char_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_queued_valid: got %b want 1", char_valid_o); end
    rx_q.delete();
    rst_ni = 1'b0;
    char_ready_i = 1'b1;
    #1;
    n_cmp++; if (char_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", char_valid_o); end
    n_cmp++; if (char_o !== 8'h00) begin n_fail++; $display("FAIL mid_async_char: got %h want 0", char_o); end
    n_cmp++; if (stop_o !== 1'b0) begin n_fail++; $display("FAIL mid_async_stop: got %b want 0", stop_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    rd(A_STATUS, d);
    n_cmp++; if (d !== 64'h0) begin n_fail++; $display("FAIL mid_status: got %h want 0", d); end
    n_cmp++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL mid_no_pop: got %0d want 0", rx_q.size()); end
    n_cmp++; if (char_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_after_valid: got %b want 0", char_valid_o); end
  endtask

  initial begin
    test_reset();
    test_print_order();
    test_strb();
    test_full_push_pop();
    test_overflow();
    test_stop();
    test_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
